axi4_burst_master: RTL and testbench

//  AXI4 full-protocol initiator: turns a simple command + data-stream interface into single INCR bursts on an M00 AXI4 port.

---
 rtl/axi4_pkg.sv | 29 ++
 rtl/axi4_beat_counter.sv | 34 +++
 rtl/axi4_burst_master.sv | 186 ++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, FSM encodings and helpers for the burst master and
// its beat counter.
package axi4_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam axi_resp_t  RESP_OKAY   = 2'b00;
   localparam axi_resp_t  RESP_EXOKAY = 2'b01;
   localparam axi_resp_t  RESP_SLVERR = 2'b10;
   localparam axi_resp_t  RESP_DECERR = 2'b11;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AW   = 3'd1;
   localparam logic [2:0] ST_W    = 3'd2;
   localparam logic [2:0] ST_B    = 3'd3;
   localparam logic [2:0] ST_AR   = 3'd4;
   localparam logic [2:0] ST_R    = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   function automatic int clogb2(input int value);
      int r;
      for (r = 0; (1 << r) < value; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/axi4_beat_counter.sv
// Beat counter shared by the W and R phases: cleared on command accept,
// bumped on each beat handshake, flags the beat whose index equals len.
module axi4_beat_counter
   import axi4_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic       inc_i,
   input  logic [7:0] len_i,
   output logic       last_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Full 8-bit compare, so len=255 reaches last before any wrap.
   assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 initiator: one INCR burst per command, one transaction in flight,
// with done/err reported per command.
module axi4_burst_master
   import axi4_pkg::*;
#(
   parameter int C_M00_AXI_ID_WIDTH   = 1,
   parameter int C_M00_AXI_DATA_WIDTH = 32,
   parameter int C_M00_AXI_ADDR_WIDTH = 13
) (
   input  logic                                m00_axi_aclk,
   input  logic                                m00_axi_areset,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic                                cmd_write,
   input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [7:0]                          cmd_len,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]     wr_data,
   input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   wr_strb,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]     rd_data,
   output logic                                rd_valid,
   input  logic                                rd_ready,
   output logic                                done,
   output logic                                err,
   output logic [C_M00_AXI_ID_WIDTH-1:0]       m00_axi_awid,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
   output logic [7:0]                          m00_axi_awlen,
   output logic [2:0]                          m00_axi_awsize,
   output logic [1:0]                          m00_axi_awburst,
   output logic                                m00_axi_awlock,
   output logic [3:0]                          m00_axi_awcache,
   output logic [2:0]                          m00_axi_awprot,
   output logic [3:0]                          m00_axi_awqos,
   output logic [3:0]                          m00_axi_awregion,
   output logic                                m00_axi_awuser,
   output logic                                m00_axi_awvalid,
   input  logic                                m00_axi_awready,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
   output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
   output logic                                m00_axi_wlast,
   output logic                                m00_axi_wuser,
   output logic                                m00_axi_wvalid,
   input  logic                                m00_axi_wready,
   input  logic [C_M00_AXI_ID_WIDTH-1:0]       m00_axi_bid,
   input  logic [1:0]                          m00_axi_bresp,
   input  logic                                m00_axi_buser,
   input  logic                                m00_axi_bvalid,
   output logic                                m00_axi_bready,
   output logic [C_M00_AXI_ID_WIDTH-1:0]       m00_axi_arid,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
   output logic [7:0]                          m00_axi_arlen,
   output logic [2:0]                          m00_axi_arsize,
   output logic [1:0]                          m00_axi_arburst,
   output logic                                m00_axi_arlock,
   output logic [3:0]                          m00_axi_arcache,
   output logic [2:0]                          m00_axi_arprot,
   output logic [3:0]                          m00_axi_arqos,
   output logic [3:0]                          m00_axi_arregion,
   output logic                                m00_axi_aruser,
   output logic                                m00_axi_arvalid,
   input  logic                                m00_axi_arready,
   input  logic [C_M00_AXI_ID_WIDTH-1:0]       m00_axi_rid,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
   input  logic [1:0]                          m00_axi_rresp,
   input  logic                                m00_axi_rlast,
   input  logic                                m00_axi_ruser,
   input  logic                                m00_axi_rvalid,
   output logic                                m00_axi_rready
);

   localparam int AXSIZE = clogb2(C_M00_AXI_DATA_WIDTH / 8);
   localparam logic [C_M00_AXI_ADDR_WIDTH-1:0] ADDR_MASK = {C_M00_AXI_ADDR_WIDTH{1'b1}} << AXSIZE;

   logic [2:0]                      state_q, state_d;
   logic [C_M00_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                      len_q, len_d;
   logic                            err_q, err_d;
   logic                            cnt_load, cnt_inc, cnt_last;
   logic                            unused_sigs;

   axi4_beat_counter u_beat_cnt (
      .clk_i  (m00_axi_aclk),
      .rst_i  (m00_axi_areset),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .len_i  (len_q),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      err_d    = err_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_valid) begin
            addr_d   = cmd_addr & ADDR_MASK;
            len_d    = cmd_len;
            err_d    = 1'b0;
            cnt_load = 1'b1;
            state_d  = cmd_write ? ST_AW : ST_AR;
         end
         ST_AW: if (m00_axi_awready) state_d = ST_W;
         ST_W: if (wr_valid && m00_axi_wready) begin
            cnt_inc = 1'b1;
            if (cnt_last) state_d = ST_B;
         end
         ST_B: if (m00_axi_bvalid) begin
            err_d   = err_q | (m00_axi_bresp != RESP_OKAY);
            state_d = ST_DONE;
         end
         ST_AR: if (m00_axi_arready) state_d = ST_R;
         ST_R: if (m00_axi_rvalid && rd_ready) begin
            // A misplaced or missing RLAST is reported, but only RLAST ends the burst.
            cnt_inc = 1'b1;
            err_d   = err_q | (m00_axi_rresp != RESP_OKAY) | (m00_axi_rlast != cnt_last);
            if (m00_axi_rlast) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign err       = done & err_q;

   assign m00_axi_awid     = '0;
   assign m00_axi_awaddr   = addr_q;
   assign m00_axi_awlen    = len_q;
   assign m00_axi_awsize   = 3'(AXSIZE);
   assign m00_axi_awburst  = BURST_INCR;
   assign m00_axi_awvalid  = (state_q == ST_AW);
   assign m00_axi_awlock   = 1'b0;
   assign m00_axi_awcache  = '0;
   assign m00_axi_awprot   = '0;
   assign m00_axi_awqos    = '0;
   assign m00_axi_awregion = '0;
   assign m00_axi_awuser   = 1'b0;

   assign m00_axi_wdata  = wr_data;
   assign m00_axi_wstrb  = wr_strb;
   assign m00_axi_wvalid = (state_q == ST_W) & wr_valid;
   assign m00_axi_wlast  = (state_q == ST_W) & cnt_last;
   assign m00_axi_wuser  = 1'b0;
   assign wr_ready       = (state_q == ST_W) & m00_axi_wready;

   assign m00_axi_bready = (state_q == ST_B);

   assign m00_axi_arid     = '0;
   assign m00_axi_araddr   = addr_q;
   assign m00_axi_arlen    = len_q;
   assign m00_axi_arsize   = 3'(AXSIZE);
   assign m00_axi_arburst  = BURST_INCR;
   assign m00_axi_arvalid  = (state_q == ST_AR);
   assign m00_axi_arlock   = 1'b0;
   assign m00_axi_arcache  = '0;
   assign m00_axi_arprot   = '0;
   assign m00_axi_arqos    = '0;
   assign m00_axi_arregion = '0;
   assign m00_axi_aruser   = 1'b0;

   assign rd_data        = m00_axi_rdata;
   assign rd_valid       = (state_q == ST_R) & m00_axi_rvalid;
   assign m00_axi_rready = (state_q == ST_R) & rd_ready;

   assign unused_sigs = ^{m00_axi_bid, m00_axi_rid, m00_axi_buser, m00_axi_ruser};

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench: behavioural AXI4 memory responder plus a table of commands
// with hand-computed expectations, then a mid-burst reset sequence.
module tb_axi4_burst_master;

   localparam int IDW = 1;
   localparam int DW  = 32;
   localparam int AW  = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic areset;
   logic cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [7:0] cmd_len;
   logic [DW-1:0] wr_data, rd_data;
   logic [3:0] wr_strb;
   logic wr_valid, wr_ready, rd_valid, rd_ready, done, err;
   logic [IDW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize, awprot, arprot;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awlock, arlock, awuser, aruser, wuser, buser, ruser;
   logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
   logic awvalid, awready, arvalid, arready;
   logic [DW-1:0] wdata, rdata;
   logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

   axi4_burst_master #(.C_M00_AXI_ID_WIDTH(IDW), .C_M00_AXI_DATA_WIDTH(DW), .C_M00_AXI_ADDR_WIDTH(AW)) dut (
      .m00_axi_aclk(clk), .m00_axi_areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done), .err(err),
      .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
      .m00_axi_awburst(awburst), .m00_axi_awlock(awlock), .m00_axi_awcache(awcache), .m00_axi_awprot(awprot),
      .m00_axi_awqos(awqos), .m00_axi_awregion(awregion), .m00_axi_awuser(awuser),
      .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
      .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast), .m00_axi_wuser(wuser),
      .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
      .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_buser(buser), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
      .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
      .m00_axi_arburst(arburst), .m00_axi_arlock(arlock), .m00_axi_arcache(arcache), .m00_axi_arprot(arprot),
      .m00_axi_arqos(arqos), .m00_axi_arregion(arregion), .m00_axi_aruser(aruser),
      .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
      .m00_axi_rid(rid), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
      .m00_axi_ruser(ruser), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
   );

   typedef struct {
      logic        wr;
      logic [12:0] addr;
      logic [7:0]  len;
      logic [31:0] base;      // first data word written / expected on read
      int          dly;       // AxREADY delay in cycles
      logic [1:0]  bresp;
      logic        gaps;      // random stalls on all streams
      int          rlast_at;  // beat index where the responder raises RLAST
      logic [12:0] exp_addr;
      int          exp_beats;
      logic        exp_err;
   } vec_t;
   vec_t tbl [11];

   int n_chk = 0, n_fail = 0;
   int cyc = 0;

   // responder controls and observations
   int cur_dly = 0, rlast_at = 0, wr_total = 0;
   logic [1:0] cur_bresp = 2'b00;
   logic gaps = 1'b0;
   logic [31:0] exp_base = 0;
   logic [31:0] mem [0:2047];
   int ax_wait = 0, ax_hold = 0, stab_bad = 0;
   logic ax_seen = 1'b0, aw_done = 1'b0, b_pend = 1'b0, r_act = 1'b0, r_hold = 1'b0;
   int prev_addr = 0, prev_len = 0;
   int cap_addr = -1, cap_len = -1, cap_size = -1, cap_burst = -1;
   int w_beat = 0, wr_idx = 0, wlast_cnt = 0, wlast_bad = 0, w_early = 0, wdata_bad = 0;
   int r_word = 0, r_beat = 0, rd_idx = 0, rd_bad = 0, last_hs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic string nm(input int idx, input string s);
      return $sformatf("v%0d_%s", idx, s);
   endfunction

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   task automatic clear_cnt();
      ax_wait = 0; ax_hold = 0; stab_bad = 0; ax_seen = 1'b0; aw_done = 1'b0;
      cap_addr = -1; cap_len = -1; cap_size = -1; cap_burst = -1;
      w_beat = 0; wr_idx = 0; wlast_cnt = 0; wlast_bad = 0; w_early = 0; wdata_bad = 0;
      r_beat = 0; rd_idx = 0; rd_bad = 0; last_hs = -100;
   endtask

   // Responder: drives slave and user-stream inputs on the falling edge, then
   // resolves which handshakes the next rising edge will complete.
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         awready  = awvalid && (ax_wait >= cur_dly);
         arready  = arvalid && (ax_wait >= cur_dly);
         wready   = gaps ? ($urandom_range(3) != 0) : 1'b1;
         wr_valid = (wr_idx < wr_total) && (gaps ? ($urandom_range(3) != 0) : 1'b1);
         wr_data  = exp_base + 32'(wr_idx);
         bvalid   = b_pend;
         bresp    = cur_bresp;
         if (!r_hold) rvalid = r_act && (gaps ? ($urandom_range(3) != 0) : 1'b1);
         rdata    = mem[(r_word + r_beat) & 2047];
         rlast    = (r_beat == rlast_at);
         rresp    = 2'b00;
         rd_ready = gaps ? ($urandom_range(3) != 0) : 1'b1;
         #2;
         if (areset) begin
            aw_done = 1'b0; b_pend = 1'b0; r_act = 1'b0; r_hold = 1'b0; ax_wait = 0; ax_seen = 1'b0;
         end else begin
            if (awvalid || arvalid) begin
               ax_hold++;
               if (ax_seen && (prev_addr != int'(awvalid ? awaddr : araddr) ||
                               prev_len != int'(awvalid ? awlen : arlen))) stab_bad++;
               prev_addr = int'(awvalid ? awaddr : araddr);
               prev_len  = int'(awvalid ? awlen : arlen);
               ax_seen   = 1'b1;
               if (awready || arready) begin
                  cap_addr = prev_addr; cap_len = prev_len;
                  cap_size = int'(awvalid ? awsize : arsize);
                  cap_burst = int'(awvalid ? awburst : arburst);
                  ax_seen = 1'b0; ax_wait = 0;
                  if (awvalid) aw_done = 1'b1;
                  else begin r_act = 1'b1; r_beat = 0; r_word = cap_addr >> 2; end
               end else ax_wait++;
            end
            if (wvalid && !aw_done) w_early++;
            if (wvalid && wready) begin
               if (wdata != exp_base + 32'(w_beat)) wdata_bad++;
               mem[((cap_addr >> 2) + w_beat) & 2047] = wdata;
               if (wlast != (w_beat == cap_len)) wlast_bad++;
               if (wlast) begin wlast_cnt++; b_pend = 1'b1; end
               w_beat++;
            end
            if (wr_valid && wr_ready) wr_idx++;
            if (bvalid && bready) begin b_pend = 1'b0; last_hs = cyc; end
            if (rvalid && rready) begin
               r_hold = 1'b0;
               if (rlast) begin r_act = 1'b0; last_hs = cyc; end
               r_beat++;
            end else if (rvalid) r_hold = 1'b1;
            if (rd_valid && rd_ready) begin
               if (rd_data != exp_base + 32'(rd_idx)) rd_bad++;
               rd_idx++;
            end
         end
      end
   end

   task automatic run_vec(input int idx);
      vec_t v;
      int t, done_cyc;
      logic seen;
      v = tbl[idx];
      cur_dly = v.dly; cur_bresp = v.bresp; gaps = v.gaps; rlast_at = v.rlast_at; exp_base = v.base;
      clear_cnt();
      wr_total = v.wr ? v.exp_beats : 0;
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
      t = 0;
      while (!cmd_ready && t < 20) begin tick(); t++; end
      chk(nm(idx, "accept"), 32'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      chk(nm(idx, "axvalid_lat"), 32'(v.wr ? awvalid : arvalid), 1);
      seen = 1'b0; done_cyc = 0; t = 0;
      while (!seen && t < 3000) begin
         if (done) begin seen = 1'b1; done_cyc = cyc; end
         else begin tick(); t++; end
      end
      chk(nm(idx, "done_seen"), 32'(seen), 1);
      chk(nm(idx, "err"), 32'(err), 32'(v.exp_err));
      chk(nm(idx, "done_lat"), 32'(done_cyc - last_hs), 1);
      tick();
      chk(nm(idx, "done_pulse"), 32'(done), 0);
      chk(nm(idx, "cmd_ready_after"), 32'(cmd_ready), 1);
      chk(nm(idx, "axaddr"), 32'(cap_addr), 32'(v.exp_addr));
      chk(nm(idx, "axlen"), 32'(cap_len), 32'(v.len));
      chk(nm(idx, "axsize"), 32'(cap_size), 2);
      chk(nm(idx, "axburst"), 32'(cap_burst), 1);
      chk(nm(idx, "ax_stable"), 32'(stab_bad), 0);
      chk(nm(idx, "ax_hold"), 32'(ax_hold), 32'(v.dly + 1));
      if (v.wr) begin
         chk(nm(idx, "w_beats"), 32'(w_beat), 32'(v.exp_beats));
         chk(nm(idx, "wlast_cnt"), 32'(wlast_cnt), 1);
         chk(nm(idx, "wlast_pos"), 32'(wlast_bad), 0);
         chk(nm(idx, "w_before_aw"), 32'(w_early), 0);
         chk(nm(idx, "wdata"), 32'(wdata_bad), 0);
      end else begin
         chk(nm(idx, "r_beats"), 32'(rd_idx), 32'(v.exp_beats));
         chk(nm(idx, "rdata"), 32'(rd_bad), 0);
      end
   endtask

   initial begin
      int t, n_done;
      tbl[0]  = '{1'b1, 13'h003, 8'd7,   32'h12345678, 0, 2'b00, 1'b0, 7,   13'h000, 8,   1'b0};
      tbl[1]  = '{1'b0, 13'h000, 8'd7,   32'h12345678, 0, 2'b00, 1'b0, 7,   13'h000, 8,   1'b0};
      tbl[2]  = '{1'b1, 13'h105, 8'd0,   32'hA5A50000, 5, 2'b00, 1'b0, 0,   13'h104, 1,   1'b0};
      tbl[3]  = '{1'b1, 13'h200, 8'd3,   32'h0BAD0000, 0, 2'b10, 1'b0, 3,   13'h200, 4,   1'b1};
      tbl[4]  = '{1'b0, 13'h104, 8'd0,   32'hA5A50000, 2, 2'b00, 1'b0, 0,   13'h104, 1,   1'b0};
      tbl[5]  = '{1'b1, 13'h400, 8'd255, 32'hC0DE0000, 0, 2'b00, 1'b1, 255, 13'h400, 256, 1'b0};
      tbl[6]  = '{1'b0, 13'h403, 8'd255, 32'hC0DE0000, 0, 2'b00, 1'b1, 255, 13'h400, 256, 1'b0};
      tbl[7]  = '{1'b0, 13'h000, 8'd3,   32'h12345678, 0, 2'b00, 1'b0, 1,   13'h000, 2,   1'b1};
      tbl[8]  = '{1'b0, 13'h200, 8'd3,   32'h0BAD0000, 0, 2'b00, 1'b0, 3,   13'h200, 4,   1'b0};
      tbl[9]  = '{1'b1, 13'h600, 8'd1,   32'h55550000, 0, 2'b00, 1'b0, 1,   13'h600, 2,   1'b0};
      tbl[10] = '{1'b0, 13'h602, 8'd1,   32'h55550000, 0, 2'b00, 1'b0, 1,   13'h600, 2,   1'b0};

      areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_strb = 4'hF; wr_valid = 1'b0; rd_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bid = '0; bresp = 2'b00; buser = 1'b0; bvalid = 1'b0;
      rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; ruser = 1'b0; rvalid = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", 32'({awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, done, err}), 0);
      chk("tieoffs", 32'({awlock, awcache, awprot, awqos, awregion, awuser, wuser,
                          arlock, arcache, arprot, arqos, arregion, aruser, awid, arid}), 0);
      areset = 1'b0;
      tick();
      chk("reset_cmd_ready", 32'(cmd_ready), 1);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Reset while beat 3 of a len=7 write is on the bus.
      clear_cnt();
      cur_dly = 0; gaps = 1'b0; cur_bresp = 2'b00; rlast_at = 7; exp_base = 32'h77770000; wr_total = 8;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h600; cmd_len = 8'd7;
      tick();
      cmd_valid = 1'b0;
      t = 0;
      while (w_beat < 3 && t < 50) begin tick(); t++; end
      chk("rst_reach_beat3", 32'(w_beat), 3);
      chk("rst_wvalid_before", 32'(wvalid), 1);
      areset = 1'b1;
      tick();
      chk("rst_valids", 32'({awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, wr_ready, done, err}), 0);
      n_done = 0;
      repeat (2) begin tick(); if (done) n_done++; end
      areset = 1'b0;
      tick();
      chk("rst_no_done", 32'(n_done + int'(done)), 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      run_vec(9);
      run_vec(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
